// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame geometry, sampling window and FSM state encoding.
package uart_defs;
    localparam int OVERSAMPLE     = 16;
    localparam int SAMPLE_FIRST   = 7;
    localparam int SAMPLE_LAST    = 9;
    localparam int DATA_BITS      = 8;
    localparam int STOP_BIT_INDEX = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } uart_state_t;

    // 2-of-3 majority used for the per-bit decision
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-controller signal bundle: serial line in, byte/strobes out.
interface uart_rx_if;
    logic       rx;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       recv_error;

    modport master (input rx, output received, output rx_byte, output is_receiving, output recv_error);
    modport slave  (output rx, input received, input rx_byte, input is_receiving, input recv_error);
endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-clock tick every CLOCK_DIVIDE clocks, phase reset by clear.
module uart_tick_gen #(
    parameter int CLOCK_DIVIDE = 78
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(CLOCK_DIVIDE - 1);

    logic [15:0] count;

    assign tick = (count == LAST);

    // Divider: count 0..CLOCK_DIVIDE-1, restart on terminal count or clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, valid/error strobes.
module uart_rx
    import uart_defs::*;
#(
    parameter int CLOCK_DIVIDE = 78
) (
    input logic        clock,
    input logic        reset_n,
    uart_rx_if.master  bus
);
    localparam logic [3:0] SUB_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SUB_FIRST = 4'(SAMPLE_FIRST);
    localparam logic [3:0] SUB_MID   = 4'(SAMPLE_FIRST + 1);
    localparam logic [3:0] SUB_DEC   = 4'(SAMPLE_LAST);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS);

    uart_state_t state, next_state;
    logic        sync_p0, rxs;
    logic        tick, clear, decide, maj;
    logic        load_byte, frame_err, shift_en, busy;
    logic [3:0]  sub, bit_idx;
    logic        samp_first, samp_mid;
    logic [7:0]  shreg;

    uart_tick_gen #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .tick    (tick)
    );

    assign decide = tick && (sub == SUB_DEC);
    assign maj    = majority3(samp_first, samp_mid, rxs);

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            sync_p0 <= bus.rx;
            rxs     <= sync_p0;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic; STOP returns to IDLE at mid-stop so a following start edge is caught
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rxs) next_state = START;
            START:   if (decide) next_state = maj ? IDLE : DATA;
            DATA:    if (decide && (bit_idx == BIT_LAST)) next_state = STOP;
            STOP:    if (decide) next_state = maj ? IDLE : RECOVER;
            RECOVER: if (rxs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from state and the bit decision
    always_comb begin
        clear     = (state == IDLE);
        busy      = (state != IDLE);
        shift_en  = (state == DATA) && decide;
        load_byte = (state == STOP) && decide && maj;
        frame_err = (state == STOP) && decide && !maj;
    end

    assign bus.is_receiving = busy;

    // Frame position counters, held at zero while idle so they align to the start edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sub     <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            sub     <= '0;
            bit_idx <= '0;
        end else if (tick) begin
            if (sub == SUB_LAST) begin
                sub     <= '0;
                bit_idx <= bit_idx + 4'd1;
            end else begin
                sub <= sub + 4'd1;
            end
        end
    end

    // Sample capture and LSB-first shift register (datapath, no reset needed)
    always_ff @(posedge clock) begin
        if (tick && (sub == SUB_FIRST)) samp_first <= rxs;
        if (tick && (sub == SUB_MID))   samp_mid   <= rxs;
        if (shift_en)                   shreg      <= {maj, shreg[7:1]};
    end

    // Registered output strobes and held byte
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.received   <= 1'b0;
            bus.recv_error <= 1'b0;
            bus.rx_byte    <= 8'h00;
        end else begin
            bus.received   <= load_byte;
            bus.recv_error <= frame_err;
            if (load_byte) bus.rx_byte <= shreg;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with CLOCK_DIVIDE=2 (32 clocks per bit).
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   err_cnt = 0;
    int   busy_viol = 0;
    int   both_viol = 0;
    logic [7:0] rx_log[$];
    int         cyc_log[$];

    uart_rx_if u_if ();

    uart_rx #(.CLOCK_DIVIDE(2)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge
    always @(negedge clk) begin
        if (u_if.received) begin
            rx_log.push_back(u_if.rx_byte);
            cyc_log.push_back(cyc);
            if (u_if.is_receiving) busy_viol <= busy_viol + 1;
            if (u_if.recv_error) both_viol <= both_viol + 1;
        end
        if (u_if.recv_error) err_cnt <= err_cnt + 1;
    end

    task automatic send_bit(input logic v);
        u_if.rx = v;
        repeat (32) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        u_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (u_if.received !== 1'b0) begin fails++; $display("FAIL reset_received: got %b expected 0", u_if.received); end
        checks++; if (u_if.recv_error !== 1'b0) begin fails++; $display("FAIL reset_recv_error: got %b expected 0", u_if.recv_error); end
        checks++; if (u_if.is_receiving !== 1'b0) begin fails++; $display("FAIL reset_is_receiving: got %b expected 0", u_if.is_receiving); end
        checks++; if (u_if.rx_byte !== 8'h00) begin fails++; $display("FAIL reset_rx_byte: got %h expected 00", u_if.rx_byte); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single;
        int n0, e0, c0, lat;
        logic [7:0] got;
        n0 = rx_log.size(); e0 = err_cnt; c0 = cyc;
        send_frame(8'h55, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (rx_log.size() !== n0 + 1) begin fails++; $display("FAIL single_count: got %0d expected %0d", rx_log.size() - n0, 1); end
        got = (rx_log.size() > n0) ? rx_log[n0] : 8'hxx;
        checks++; if (got !== 8'h55) begin fails++; $display("FAIL single_byte: got %h expected 55", got); end
        lat = (cyc_log.size() > n0) ? cyc_log[n0] - c0 : -1;
        checks++; if (lat < 308 || lat > 312) begin fails++; $display("FAIL single_latency: got %0d expected 310+-2", lat); end
        checks++; if (err_cnt !== e0) begin fails++; $display("FAIL single_error: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        int n0, d;
        logic [7:0] g0, g1;
        n0 = rx_log.size();
        send_frame(8'hCD, 1'b1);
        send_frame(8'h42, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (rx_log.size() !== n0 + 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", rx_log.size() - n0); end
        g0 = (rx_log.size() > n0) ? rx_log[n0] : 8'hxx;
        g1 = (rx_log.size() > n0 + 1) ? rx_log[n0 + 1] : 8'hxx;
        checks++; if (g0 !== 8'hCD) begin fails++; $display("FAIL b2b_byte0: got %h expected cd", g0); end
        checks++; if (g1 !== 8'h42) begin fails++; $display("FAIL b2b_byte1: got %h expected 42", g1); end
        d = (cyc_log.size() > n0 + 1) ? cyc_log[n0 + 1] - cyc_log[n0] : -1;
        checks++; if (d < 319 || d > 321) begin fails++; $display("FAIL b2b_spacing: got %0d expected 320+-1", d); end
    endtask

    task automatic test_glitch_start;
        int n0, e0;
        logic busy_early, busy_late;
        n0 = rx_log.size(); e0 = err_cnt;
        u_if.rx = 1'b0;
        repeat (6) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (4) @(negedge clk);
        busy_early = u_if.is_receiving;
        repeat (20) @(negedge clk);
        busy_late = u_if.is_receiving;
        repeat (20) @(negedge clk);
        checks++; if (busy_early !== 1'b1) begin fails++; $display("FAIL glitch_busy_high: got %b expected 1", busy_early); end
        checks++; if (busy_late !== 1'b0) begin fails++; $display("FAIL glitch_busy_low: got %b expected 0", busy_late); end
        checks++; if (rx_log.size() !== n0) begin fails++; $display("FAIL glitch_no_received: got %0d expected 0", rx_log.size() - n0); end
        checks++; if (err_cnt !== e0) begin fails++; $display("FAIL glitch_no_error: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_framing_error;
        int n0, e0;
        logic busy_mid;
        logic [7:0] got;
        n0 = rx_log.size(); e0 = err_cnt;
        send_frame(8'hA5, 1'b0);
        u_if.rx = 1'b0;
        repeat (48) @(negedge clk);
        busy_mid = u_if.is_receiving;
        repeat (48) @(negedge clk);
        checks++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL ferr_error_count: got %0d expected 1", err_cnt - e0); end
        checks++; if (rx_log.size() !== n0) begin fails++; $display("FAIL ferr_no_received: got %0d expected 0", rx_log.size() - n0); end
        checks++; if (u_if.rx_byte !== 8'h42) begin fails++; $display("FAIL ferr_byte_kept: got %h expected 42", u_if.rx_byte); end
        checks++; if (busy_mid !== 1'b1) begin fails++; $display("FAIL ferr_busy_in_break: got %b expected 1", busy_mid); end
        send_bit(1'b1);
        checks++; if (u_if.is_receiving !== 1'b0) begin fails++; $display("FAIL ferr_recovered: got %b expected 0", u_if.is_receiving); end
        send_frame(8'h0E, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (rx_log.size() !== n0 + 1) begin fails++; $display("FAIL ferr_next_count: got %0d expected 1", rx_log.size() - n0); end
        got = (rx_log.size() > n0) ? rx_log[n0] : 8'hxx;
        checks++; if (got !== 8'h0E) begin fails++; $display("FAIL ferr_next_byte: got %h expected 0e", got); end
        checks++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL ferr_no_extra_error: got %0d expected 1", err_cnt - e0); end
    endtask

    task automatic test_majority_vote;
        int n0;
        logic [7:0] b, got;
        b = 8'h10;
        n0 = rx_log.size();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                u_if.rx = b[i];
                repeat (18) @(negedge clk);
                u_if.rx = ~b[i];
                repeat (2) @(negedge clk);
                u_if.rx = b[i];
                repeat (12) @(negedge clk);
            end else begin
                send_bit(b[i]);
            end
        end
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        got = (rx_log.size() > n0) ? rx_log[n0] : 8'hxx;
        checks++; if (got !== 8'h10) begin fails++; $display("FAIL vote_byte: got %h expected 10", got); end
        checks++; if (rx_log.size() !== n0 + 1) begin fails++; $display("FAIL vote_count: got %0d expected 1", rx_log.size() - n0); end
    endtask

    task automatic test_reset_abort;
        int n0;
        logic [7:0] b, got;
        b = 8'h44;
        n0 = rx_log.size();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        u_if.rx = b[3];
        repeat (16) @(negedge clk);
        reset_n = 1'b0;
        u_if.rx = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (u_if.received !== 1'b0) begin fails++; $display("FAIL abort_received: got %b expected 0", u_if.received); end
        checks++; if (u_if.recv_error !== 1'b0) begin fails++; $display("FAIL abort_recv_error: got %b expected 0", u_if.recv_error); end
        checks++; if (u_if.is_receiving !== 1'b0) begin fails++; $display("FAIL abort_is_receiving: got %b expected 0", u_if.is_receiving); end
        checks++; if (u_if.rx_byte !== 8'h00) begin fails++; $display("FAIL abort_rx_byte: got %h expected 00", u_if.rx_byte); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (400) @(negedge clk);
        checks++; if (rx_log.size() !== n0) begin fails++; $display("FAIL abort_no_pulse: got %0d expected 0", rx_log.size() - n0); end
        send_frame(8'h46, 1'b1);
        repeat (10) @(negedge clk);
        got = (rx_log.size() > n0) ? rx_log[n0] : 8'hxx;
        checks++; if (got !== 8'h46) begin fails++; $display("FAIL abort_next_byte: got %h expected 46", got); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch_start();
        test_framing_error();
        test_majority_vote();
        test_reset_abort();
        checks++; if (busy_viol !== 0) begin fails++; $display("FAIL busy_with_received: got %0d expected 0", busy_viol); end
        checks++; if (both_viol !== 0) begin fails++; $display("FAIL strobes_exclusive: got %0d expected 0", both_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
